// File: rtl/line_fifo_segmented_if.sv
// ---------------------------------------------------------------------------
// line_fifo_segmented_if
// Handshake / data bundle between a pixel stream producer and the
// segmented line FIFO.
//
// Signals (direction seen from the FIFO, i.e. the slave modport):
//   cfg_load      in   strobe: latch cfg_segments and flush contents
//   cfg_segments  in   requested active segment count
//   push          in   write request
//   data_in       in   write data
//   pop           in   read request
//   data_out      out  registered read data
//   data_valid    out  data_out holds a word popped on the previous cycle
//   count         out  words stored
//   full          out  count == capacity (running only)
//   empty         out  count == 0
//   ready         out  FIFO is running
//   no_config     out  FIFO has never been configured since reset
//   overflow      out  sticky rejected-push flag   (LINE_FIFO_ERR_FLAGS_EN)
//   underflow     out  sticky rejected-pop flag    (LINE_FIFO_ERR_FLAGS_EN)
//
// Optional feature macro: LINE_FIFO_ERR_FLAGS_EN
// ---------------------------------------------------------------------------
interface line_fifo_segmented_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_SEGMENTS = 4,
  parameter int SEG_DEPTH    = 8
);
  localparam int SEG_W = $clog2(NUM_SEGMENTS + 1);
  localparam int CNT_W = $clog2(NUM_SEGMENTS * SEG_DEPTH + 1);

  logic                  cfg_load;
  logic [SEG_W-1:0]      cfg_segments;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  ready;
  logic                  no_config;
`ifdef LINE_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output cfg_load, cfg_segments, push, data_in, pop,
`ifdef LINE_FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  data_out, data_valid, count, full, empty, ready, no_config
  );

  modport slave (
    input  cfg_load, cfg_segments, push, data_in, pop,
`ifdef LINE_FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output data_out, data_valid, count, full, empty, ready, no_config
  );
endinterface

// File: rtl/line_fifo_segmented.sv
// ---------------------------------------------------------------------------
// line_fifo_segmented
// Runtime-configurable line buffer FIFO. One RAM of NUM_SEGMENTS*SEG_DEPTH
// words; the active depth is cfg_segments*SEG_DEPTH and pointers wrap at
// that active depth, so the segment count can change without resynthesis.
// Every accepted reconfiguration passes through a one-cycle flush that
// discards all contents.
//
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   fifo     line_fifo_segmented_if.slave (config, push/pop, data, status)
//
// Optional feature macro: LINE_FIFO_ERR_FLAGS_EN
//   defined   -> sticky overflow/underflow flags, cleared by reset or an
//                accepted cfg_load
//   undefined -> flags and their logic absent
// ---------------------------------------------------------------------------
module line_fifo_segmented #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_SEGMENTS = 4,
  parameter int SEG_DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  line_fifo_segmented_if.slave fifo
);

  localparam int DEPTH = NUM_SEGMENTS * SEG_DEPTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SEG_W = $clog2(NUM_SEGMENTS + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_UNCONF = 2'd0,
    S_FLUSH  = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [SEG_W-1:0]      seg_pend_q;
  logic [CNT_W-1:0]      capacity_q;
  logic [CNT_W-1:0]      count_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  logic                  cfg_ok;
  logic                  take_cfg;
  logic                  run_ops;
  logic                  full_c;
  logic                  empty_c;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  wr_last;
  logic                  rd_last;
  logic [AW-1:0]         wr_ptr_nxt;
  logic [AW-1:0]         rd_ptr_nxt;
  logic                  ready_c;
  logic                  no_config_c;

  // A load request only counts when it asks for 1..NUM_SEGMENTS segments.
  assign cfg_ok   = fifo.cfg_load
                  && (fifo.cfg_segments != '0)
                  && (fifo.cfg_segments <= SEG_W'(NUM_SEGMENTS));
  // The flush cycle itself cannot be re-entered by another load.
  assign take_cfg = cfg_ok && (state_q != S_FLUSH);

  // An accepted reconfiguration overrides any push/pop in the same cycle.
  assign run_ops  = (state_q == S_RUN) && !take_cfg;

  assign full_c   = (state_q == S_RUN) && (count_q == capacity_q);
  assign empty_c  = (count_q == '0);

  assign pop_acc  = run_ops && fifo.pop && !empty_c;
  assign push_acc = run_ops && fifo.push && (!full_c || pop_acc);

  // Pointers wrap at the active capacity, not at the physical RAM depth.
  assign wr_last    = (CNT_W'(wr_ptr_q) == (capacity_q - CNT_W'(1)));
  assign rd_last    = (CNT_W'(rd_ptr_q) == (capacity_q - CNT_W'(1)));
  assign wr_ptr_nxt = wr_last ? '0 : (wr_ptr_q + AW'(1));
  assign rd_ptr_nxt = rd_last ? '0 : (rd_ptr_q + AW'(1));

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    no_config_c = 1'b0;
    case (state_q)
      S_UNCONF: begin
        no_config_c = 1'b1;
        if (cfg_ok) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        ready_c = 1'b1;
        if (cfg_ok) state_d = S_FLUSH;
      end
      default: begin
        state_d = S_UNCONF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_UNCONF;
      seg_pend_q <= '0;
      capacity_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take_cfg) seg_pend_q <= fifo.cfg_segments;
      if (state_q == S_FLUSH) begin
        capacity_q <= CNT_W'(seg_pend_q) * CNT_W'(SEG_DEPTH);
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (push_acc) wr_ptr_q <= wr_ptr_nxt;
        if (pop_acc)  rd_ptr_q <= rd_ptr_nxt;
        if (push_acc && !pop_acc)      count_q <= count_q + CNT_W'(1);
        else if (pop_acc && !push_acc) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Storage array: no reset, contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= fifo.data_in;
  end

  // ---- stage p1: registered read data, one cycle after the accepted pop ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= pop_acc;
      if (pop_acc) rd_data_p1 <= mem[rd_ptr_q];
    end
  end

`ifdef LINE_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (take_cfg) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (run_ops && fifo.push && !push_acc) overflow_q  <= 1'b1;
      if (run_ops && fifo.pop && empty_c)    underflow_q <= 1'b1;
    end
  end

  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;
`endif

  assign fifo.data_out   = rd_data_p1;
  assign fifo.data_valid = vld_p1;
  assign fifo.count      = count_q;
  assign fifo.full       = full_c;
  assign fifo.empty      = empty_c;
  assign fifo.ready      = ready_c;
  assign fifo.no_config  = no_config_c;

endmodule

// File: tb/tb_line_fifo_segmented.sv
// Testbench for line_fifo_segmented: directed scenarios plus a randomized
// run, all checked against a queue-based reference model of the FIFO.
module tb_line_fifo_segmented;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int SD = 8;
  localparam int CW = $clog2(NS * SD + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  line_fifo_segmented_if #(.DATA_WIDTH(DW), .NUM_SEGMENTS(NS), .SEG_DEPTH(SD)) bus ();

  line_fifo_segmented #(.DATA_WIDTH(DW), .NUM_SEGMENTS(NS), .SEG_DEPTH(SD)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .fifo   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = unconfigured, 1 = flushing, 2 = running.
  logic [DW-1:0] mq[$];
  int            m_mode;
  int            m_cap;
  int            m_pend;
  logic [DW-1:0] e_dout;
  logic          e_dv;
  logic          e_ovf;
  logic          e_udf;
  logic [CW-1:0] e_count;
  logic          e_full;
  logic          e_empty;
  logic          e_ready;
  logic          e_nocfg;

  function automatic void model_outputs();
    e_count = CW'(mq.size());
    e_empty = (mq.size() == 0);
    e_full  = (m_mode == 2) && (mq.size() == m_cap);
    e_ready = (m_mode == 2);
    e_nocfg = (m_mode == 0);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_mode = 0; m_cap = 0; m_pend = 0;
    e_dout = '0; e_dv = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
    model_outputs();
  endfunction

  function automatic void model_step(input bit ps, input logic [DW-1:0] d, input bit pp,
                                     input bit cl, input int cs);
    bit cfg_ok, do_pop, do_push;
    cfg_ok = cl && (cs >= 1) && (cs <= NS);
    e_dv = 1'b0;
    if (m_mode == 1) begin
      m_cap = m_pend * SD;
      mq.delete();
      m_mode = 2;
    end else if (cfg_ok) begin
      m_pend = cs;
      m_mode = 1;
      e_ovf = 1'b0; e_udf = 1'b0;
    end else if (m_mode == 2) begin
      do_pop  = pp && (mq.size() > 0);
      do_push = ps && ((mq.size() < m_cap) || do_pop);
      if (ps && !do_push) e_ovf = 1'b1;
      if (pp && mq.size() == 0) e_udf = 1'b1;
      if (do_pop) begin e_dout = mq.pop_front(); e_dv = 1'b1; end
      if (do_push) mq.push_back(d);
    end
    model_outputs();
  endfunction

  // Drive one clock cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic cycle(input bit ps, input logic [DW-1:0] d, input bit pp,
                       input bit cl, input int cs);
    bus.push = ps; bus.data_in = d; bus.pop = pp;
    bus.cfg_load = cl; bus.cfg_segments = 3'(cs);
    model_step(ps, d, pp, cl, cs);
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_dout: got %0h want 0", bus.data_out); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_dv: got %0b want 0", bus.data_valid); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0b want 0", bus.full); end
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 0);
      total++; if (bus.no_config !== 1'b1) begin bad++; $display("FAIL unconf_nocfg: got %0b want 1", bus.no_config); end
      total++; if (bus.count !== '0) begin bad++; $display("FAIL unconf_count: got %0d want 0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL unconf_empty: got %0b want 1", bus.empty); end
      total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL unconf_ready: got %0b want 0", bus.ready); end
    end
  endtask

  task automatic test_fill_drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 2);
    total++; if (bus.ready !== 1'b0 || bus.no_config !== 1'b0) begin bad++; $display("FAIL flush_state: got ready=%0b nocfg=%0b want 0 0", bus.ready, bus.no_config); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    total++; if (bus.ready !== 1'b1 || bus.empty !== 1'b1) begin bad++; $display("FAIL run_entry: got ready=%0b empty=%0b want 1 1", bus.ready, bus.empty); end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 0);
      total++; if (bus.count !== e_count || bus.full !== e_full) begin bad++; $display("FAIL fill_status: got count=%0d full=%0b want %0d %0b", bus.count, bus.full, e_count, e_full); end
    end
    total++; if (bus.full !== 1'b1 || bus.count !== CW'(16)) begin bad++; $display("FAIL fill16: got full=%0b count=%0d want 1 16", bus.full, bus.count); end
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 0);
    total++; if (bus.count !== CW'(16)) begin bad++; $display("FAIL drop_count: got %0d want 16", bus.count); end
`ifdef LINE_FIFO_ERR_FLAGS_EN
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL overflow: got %0b want 1", bus.overflow); end
`endif
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
      total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'(i)) begin bad++; $display("FAIL drain_data: got dv=%0b data=%0h want 1 %0h", bus.data_valid, bus.data_out, i); end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %0b want 1", bus.empty); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
    total++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h0F) begin bad++; $display("FAIL empty_pop: got dv=%0b data=%0h want 0 0f", bus.data_valid, bus.data_out); end
`ifdef LINE_FIFO_ERR_FLAGS_EN
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL underflow: got %0b want 1", bus.underflow); end
`endif
  endtask

  task automatic test_wrap();
    logic [DW-1:0] x;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      cycle(1'b1, x, 1'b0, 1'b0, 0);
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL wrap_count: got %0d want 1", bus.count); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
      total++; if (bus.data_valid !== 1'b1 || bus.data_out !== x) begin bad++; $display("FAIL wrap_data: got dv=%0b data=%0h want 1 %0h", bus.data_valid, bus.data_out, x); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] w[8];
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      cycle(1'b1, w[i], 1'b0, 1'b0, 0);
    end
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fp_full: got %0b want 1", bus.full); end
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 0);
    total++; if (bus.data_out !== w[0] || bus.data_valid !== 1'b1) begin bad++; $display("FAIL fp_first: got %0h dv=%0b want %0h 1", bus.data_out, bus.data_valid, w[0]); end
    total++; if (bus.count !== CW'(8) || bus.full !== 1'b1) begin bad++; $display("FAIL fp_count: got %0d full=%0b want 8 1", bus.count, bus.full); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
      total++; if (bus.data_out !== e_dout) begin bad++; $display("FAIL fp_order: got %0h want %0h", bus.data_out, e_dout); end
    end
    total++; if (bus.data_out !== 8'h55) begin bad++; $display("FAIL fp_last: got %0h want 55", bus.data_out); end
  endtask

  task automatic test_reconfig();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 3);
    total++; if (bus.ready !== 1'b0 || bus.data_valid !== 1'b0) begin bad++; $display("FAIL rc_flush: got ready=%0b dv=%0b want 0 0", bus.ready, bus.data_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    total++; if (bus.ready !== 1'b1 || bus.count !== '0 || bus.empty !== 1'b1) begin bad++; $display("FAIL rc_clear: got ready=%0b count=%0d want 1 0", bus.ready, bus.count); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rc_ign0: got ready=%0b want 1", bus.ready); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 5);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rc_ign5: got ready=%0b want 1", bus.ready); end
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 8'(i + 8'h30), 1'b0, 1'b0, 0);
      if (i == 22) begin
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rc_full23: got %0b want 0", bus.full); end
      end
    end
    total++; if (bus.full !== 1'b1 || bus.count !== CW'(24)) begin bad++; $display("FAIL rc_cap24: got full=%0b count=%0d want 1 24", bus.full, bus.count); end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 0);
    total++; if (bus.count !== CW'(24)) begin bad++; $display("FAIL rc_drop: got %0d want 24", bus.count); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(i + 8'h60), 1'b0, 1'b0, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0, 0);
    total++; if (bus.count !== CW'(6)) begin bad++; $display("FAIL ar_pre: got %0d want 6", bus.count); end
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.no_config !== 1'b1 || bus.ready !== 1'b0) begin bad++; $display("FAIL ar_state: got nocfg=%0b ready=%0b want 1 0", bus.no_config, bus.ready); end
    total++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL ar_count: got count=%0d empty=%0b full=%0b want 0 1 0", bus.count, bus.empty, bus.full); end
    total++; if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0) begin bad++; $display("FAIL ar_data: got %0h dv=%0b want 0 0", bus.data_out, bus.data_valid); end
    #2 reset_n = 1'b1;
    cycle(1'b1, 8'h12, 1'b1, 1'b0, 0);
    total++; if (bus.no_config !== 1'b1 || bus.count !== '0) begin bad++; $display("FAIL ar_after: got nocfg=%0b count=%0d want 1 0", bus.no_config, bus.count); end
  endtask

  task automatic test_random();
    bit ps, pp, cl;
    int cs;
    for (int i = 0; i < 400; i++) begin
      cl = (i == 0) || ($urandom_range(0, 39) == 0);
      cs = (i == 0) ? int'($urandom_range(1, NS)) : int'($urandom_range(0, NS + 1));
      if (((i / 50) % 2) == 0) begin
        ps = ($urandom_range(0, 3) != 0); pp = ($urandom_range(0, 3) == 0);
      end else begin
        ps = ($urandom_range(0, 3) == 0); pp = ($urandom_range(0, 3) != 0);
      end
      cycle(ps, 8'($urandom), pp, cl, cs);
      total++; if (bus.count !== e_count) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, bus.count, e_count); end
      total++; if (bus.full !== e_full || bus.empty !== e_empty) begin bad++; $display("FAIL rnd_flags@%0d: got full=%0b empty=%0b want %0b %0b", i, bus.full, bus.empty, e_full, e_empty); end
      total++; if (bus.ready !== e_ready || bus.no_config !== e_nocfg) begin bad++; $display("FAIL rnd_state@%0d: got ready=%0b nocfg=%0b want %0b %0b", i, bus.ready, bus.no_config, e_ready, e_nocfg); end
      total++; if (bus.data_valid !== e_dv || bus.data_out !== e_dout) begin bad++; $display("FAIL rnd_data@%0d: got dv=%0b data=%0h want %0b %0h", i, bus.data_valid, bus.data_out, e_dv, e_dout); end
`ifdef LINE_FIFO_ERR_FLAGS_EN
      total++; if (bus.overflow !== e_ovf || bus.underflow !== e_udf) begin bad++; $display("FAIL rnd_err@%0d: got ovf=%0b udf=%0b want %0b %0b", i, bus.overflow, bus.underflow, e_ovf, e_udf); end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_load = 1'b0; bus.cfg_segments = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pushpop();
    test_reconfig();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_fifo_segmented.md
Name: line_fifo_segmented

Overview:
- Runtime-configurable FIFO for filter line buffering.
- Built from NUM_SEGMENTS segments of SEG_DEPTH words each; effective depth = active_segments*SEG_DEPTH.
- The segment count can be changed at any time without resynthesis.
- Sits between the pixel input stream and the filter window, replacing fixed-count buffer chains.
- Adds depth/width parametrisation, occupancy count, simultaneous push/pop, and a controlled flush on reconfiguration.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- NUM_SEGMENTS, 4, maximum number of segments.
- SEG_DEPTH, 8, words per segment; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  strobe: latch cfg_segments and flush contents.
- cfg_segments  in  $clog2(NUM_SEGMENTS+1)  requested active segment count.
- push  in  1  write request; data_in captured when accepted.
- data_in  in  DATA_WIDTH  write data.
- pop  in  1  read request.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  data_out holds a word popped on the previous cycle.
- count  out  $clog2(NUM_SEGMENTS*SEG_DEPTH+1)  words stored.
- full  out  1  count == capacity (only while in S_RUN).
- empty  out  1  count == 0.
- ready  out  1  high in S_RUN only.
- no_config  out  1  high in S_UNCONF.

Behaviour:
- Reset (reset_n low, asynchronous): state=S_UNCONF; capacity=0; pointers=0; count=0; data_out=0; data_valid=0; full=0; empty=1; ready=0; no_config=1.
- Storage is one RAM of NUM_SEGMENTS*SEG_DEPTH words. Read and write pointers wrap to 0 after address capacity-1, not after the physical depth.

State machine:
- S_UNCONF: push and pop are ignored. A valid cfg_load goes to S_FLUSH.
- S_FLUSH: lasts exactly one cycle. Latches capacity = cfg_segments*SEG_DEPTH, clears both pointers and count, then goes to S_RUN. Push and pop are ignored; data_valid=0.
- S_RUN: normal operation. A valid cfg_load goes to S_FLUSH; contents are discarded and any push or pop in that same cycle is ignored.
- Valid cfg_load means 1 ≤ cfg_segments ≤ NUM_SEGMENTS. Otherwise cfg_load is ignored and state and contents are unchanged.

Accept rules in S_RUN:
- push_acc = push & (~full | pop_acc).
- pop_acc = pop & ~empty.
- Push and pop in the same cycle when full: both accepted, count unchanged.
- Push and pop in the same cycle when empty: push accepted, pop ignored (no fall-through).
- Push when full with no pop: dropped, count unchanged.
- Pop when empty: ignored, data_valid=0 next cycle.

Read latency and counting:
- Read latency is 1 cycle. After pop_acc at edge N, data_out is the oldest word and data_valid=1 after edge N+1.
- data_out holds its value when no pop occurs; data_valid is a one-cycle pulse per accepted pop.
- count updates on the same edge: +1 (push only), -1 (pop only), 0 (both or neither).
- full and empty are decoded combinationally from the registered count and capacity.

Reset and reconfiguration:
- Reset mid-operation clears all state immediately, regardless of clk.
- Reconfiguring to a smaller capacity never leaves stale words visible; the flush guarantees this.

Optional Feature:
- Macro: LINE_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow and underflow (1 bit each), sticky, clear on reset_n or cfg_load.
  - overflow sets when push is rejected in S_RUN because the FIFO is full.
  - underflow sets when pop is rejected in S_RUN because the FIFO is empty.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan (DATA_WIDTH=8, NUM_SEGMENTS=4, SEG_DEPTH=8):
1. Reset, no cfg_load, push 0x11 -> no_config=1, count=0, empty=1, ready=0 throughout.
2. cfg_load with cfg_segments=2, push 0x00..0x0F over 16 cycles, then push 0xAA -> full=1 at count=16; 0xAA is dropped; overflow=1 if enabled. Then pop 16 times -> data_out=0x00..0x0F in order, each valid one cycle after its pop; empty=1 at end.
3. cfg_segments=1, alternate 20 pushes and pops so the pointers wrap at address 7 -> output order preserved, count never exceeds 1.
4. cfg_segments=1, fill to 8, then push 0x55 and pop together -> popped word = first written, count stays 8, and 0x55 is read out eighth after that.
5. Load 5 words, then cfg_load cfg_segments=3 with a simultaneous push -> one S_FLUSH cycle with ready=0; then count=0, capacity=24, and the simultaneous push is ignored. Then cfg_load cfg_segments=0 or 5 -> ignored, capacity stays 24.
6. Assert reset_n between clock edges while count=6 -> all outputs return to reset values before the next edge; no_config=1.
